// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Each fetched 32-bit word carries two 16-bit instructions:
// [31:16] is group 2 and [15:0] is group 1.
package if_pkg;

    // Fetch controller states. The 2-bit encoding is visible on the debug port.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // one settling cycle after reset release
        S_WAIT = 2'd1,  // request outstanding at pc
        S_HOLD = 2'd2,  // word captured while decode was stalled
        S_DROP = 2'd3   // finishing a request made obsolete by a redirect
    } state_t;

    // Word driven into IF/ID for bubbles and flushes.
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    // Byte distance between consecutive fetch words.
    localparam int unsigned PC_INC = 4;

    // The memory request is active in every state that has a transfer in flight.
    function automatic logic is_fetching(input state_t s);
        return (s == S_WAIT) || (s == S_DROP);
    endfunction

endpackage

// File: rtl/if_fetch_stage_hold_buffer.sv
// One-entry skid buffer for a fetched word and its address.
// It fills when memory completes a read while the pipeline is stalled,
// so the word is not lost and the request does not need to be repeated.
module if_hold_buffer
    import if_pkg::*;
#(
    parameter int unsigned PC_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [31:0]     data_in,
    input  logic [PC_W-1:0] addr_in,
    output logic [31:0]     data_out,
    output logic [PC_W-1:0] addr_out,
    output logic            valid
);

    // Capture on load; clear wins so a redirect always discards the stored word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= NOP_WORD_DEFAULT;
            addr_out <= '0;
            valid    <= 1'b0;
        end else if (clear) begin
            valid    <= 1'b0;
        end else if (load) begin
            data_out <= data_in;
            addr_out <= addr_in;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Fetches one aligned 32-bit word per request, honours PCWrite/IFWrite
// stalls from hazard detection and redirect/flush from branch resolution.
//
// Memory handshake: imem_req is a request-valid, imem_ack is a one-cycle
// completion strobe. Once imem_req rises, imem_addr is held stable until
// (and including) the cycle in which imem_ack is seen; a transfer completes
// in the cycle where imem_req & imem_ack are both high. A redirect that
// arrives mid-request therefore finishes the old request in S_DROP and
// throws its data away before the new address is presented.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int unsigned      PC_W     = 16,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter logic [31:0]      NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCWrite,
    input  logic            IFWrite,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     IFID_instr,
    output logic [PC_W-1:0] IFID_pc,
    output logic            IFID_valid,
    output state_t          fsm_state
);

    // Clears the two byte-offset bits so every fetch address is word aligned.
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] stale_addr;
    logic [PC_W-1:0] target_aligned;

    logic            adv;
    logic            ack_wait;
    logic            word_avail;
    logic [31:0]     word_data;
    logic [PC_W-1:0] word_pc;

    logic            buf_load;
    logic            buf_clear;
    logic [31:0]     buf_data;
    logic [PC_W-1:0] buf_addr;
    logic            buf_valid;

    // A split PCWrite/IFWrite is treated as a full stall; hazard detection should never produce it.
    assert property (@(posedge clk) disable iff (reset) PCWrite == IFWrite);

    // Shared qualifiers for the FSM, PC and IF/ID logic.
    always_comb begin
        adv            = PCWrite & IFWrite;
        ack_wait       = (state == S_WAIT) & imem_ack;
        word_avail     = ack_wait | ((state == S_HOLD) & buf_valid);
        word_data      = (state == S_HOLD) ? buf_data : imem_rdata;
        word_pc        = (state == S_HOLD) ? buf_addr : pc;
        target_aligned = br_target & ALIGN_MASK;
        pc_inc         = pc + PC_W'(PC_INC);
        buf_load       = ack_wait & ~adv & ~br_taken;
        buf_clear      = (state == S_HOLD) & (br_taken | adv);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (br_taken) begin
                    // With ack in the same cycle the request is already complete,
                    // so the new target can be requested directly.
                    state_next = imem_ack ? S_WAIT : S_DROP;
                end else if (imem_ack && !adv) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (br_taken || adv) begin
                    state_next = S_WAIT;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    state_next = S_WAIT;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Memory interface outputs depend on state only, so the address cannot glitch mid-request.
    always_comb begin
        imem_req  = is_fetching(state);
        imem_addr = (state == S_DROP) ? stale_addr : pc;
        fsm_state = state;
    end

    // PC update: a redirect always wins, otherwise advance when a word is consumed.
    always_comb begin
        pc_next = pc;
        if (br_taken) begin
            pc_next = target_aligned;
        end else if (word_avail && adv) begin
            pc_next = pc_inc;
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Remember the address of a request interrupted by a redirect so it can be completed unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stale_addr <= '0;
        end else if ((state == S_WAIT) && br_taken && !imem_ack) begin
            stale_addr <= pc;
        end
    end

    // Skid buffer for words that arrive during a stall.
    if_hold_buffer #(
        .PC_W (PC_W)
    ) u_hold_buffer (
        .clk      (clk),
        .reset    (reset),
        .load     (buf_load),
        .clear    (buf_clear),
        .data_in  (imem_rdata),
        .addr_in  (pc),
        .data_out (buf_data),
        .addr_out (buf_addr),
        .valid    (buf_valid)
    );

    // IF/ID register: flush beats stall, stall holds, otherwise load a word or insert a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IFID_instr <= NOP_WORD;
            IFID_pc    <= '0;
            IFID_valid <= 1'b0;
        end else if (br_taken) begin
            IFID_instr <= NOP_WORD;
            IFID_valid <= 1'b0;
        end else if (!IFWrite) begin
            IFID_instr <= IFID_instr;
            IFID_pc    <= IFID_pc;
            IFID_valid <= IFID_valid;
        end else if (word_avail && adv) begin
            IFID_instr <= word_data;
            IFID_pc    <= word_pc;
            IFID_valid <= 1'b1;
        end else begin
            IFID_instr <= NOP_WORD;
            IFID_valid <= 1'b0;
        end
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit-instruction pipeline.
- Fetches one aligned 32-bit word per request; each word holds two instructions: [31:16] is group 2, [15:0] is group 1.
- Presents the word to decode and to the hazard detection circuit.
- Obeys PCWrite/IFWrite stalls from hazard detection, and redirect/flush from branch resolution.

Parameters:
- PC_W, 16, PC and instruction-address width (byte address).
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, word driven into IF/ID on bubble or flush.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- PCWrite  in  1  1 = PC may advance (from hazard detection).
- IFWrite  in  1  1 = IF/ID may load (from hazard detection).
- br_taken  in  1  branch redirect plus IF/ID flush, same cycle.
- br_target  in  PC_W  redirect address; bits [1:0] ignored (forced to 0).
- imem_req  out  1  instruction-memory request.
- imem_addr  out  PC_W  request address, word aligned.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  fetched word.
- IFID_instr  out  32  [31:16] = opcodeg2, [15:0] = opcodeg1.
- IFID_pc  out  PC_W  address of the IF/ID word.
- IFID_valid  out  1  IF/ID holds a real word.

Behaviour:
- Reset (asynchronous, any state):
  - pc=RESET_PC, state=S_IDLE, IFID_instr=NOP_WORD, IFID_pc=0, IFID_valid=0, imem_req=0, hold buffer empty.
- Definitions:
  - adv = PCWrite & IFWrite. PCWrite != IFWrite is treated as a stall; a simulation assertion flags it.
  - word_avail = (state==S_WAIT & imem_ack) | (state==S_HOLD).
- FSM:
  - S_IDLE: one cycle after reset release, then -> S_WAIT.
  - S_WAIT: imem_req=1, imem_addr=pc.
    - br_taken -> S_DROP, pc<=br_target.
    - ack & adv -> IF/ID loads rdata, pc<=pc+4, stay in S_WAIT (next request issued the following cycle).
    - ack & !adv -> rdata captured in hold buffer -> S_HOLD.
  - S_HOLD: imem_req=0.
    - br_taken -> discard buffer, pc<=br_target -> S_WAIT.
    - adv -> IF/ID loads buffer, pc<=pc+4 -> S_WAIT.
    - else stay.
  - S_DROP: imem_req=1, imem_addr=stale_addr (latched at redirect).
    - On ack: data discarded -> S_WAIT (requests the new pc).
    - A further br_taken updates pc only.
- Handshake: once imem_req rises, imem_addr is stable until the ack cycle. The address never changes mid-request; this is the reason S_DROP exists.
- IF/ID register:
  - br_taken: IFID_instr=NOP_WORD, IFID_valid=0. Highest priority, overrides stall.
  - Else IFWrite=0: hold all IF/ID outputs.
  - Else word_avail & adv: load the word, IFID_pc=address of that word, valid=1.
  - Else IFWrite=1 with no word: bubble (NOP_WORD, valid=0).
- Latency and throughput:
  - ack in cycle N -> IF/ID valid after edge N.
  - With ack in the same cycle as req, throughput is 1 word/cycle.
- PC arithmetic: pc+4 wraps modulo 2^PC_W, with no flag.
- br_taken in the same cycle as ack in S_WAIT: the acked word is discarded and the next request goes to br_target. No S_DROP is needed because the request has completed.

Decomposition:
- Package if_pkg:
  - state enum {S_IDLE, S_WAIT, S_HOLD, S_DROP}, 2-bit encoding.
  - NOP_WORD default.
  - PC increment constant 4.
- Sub-module if_hold_buffer: a 1-entry 32-bit data register plus address register with valid bit. Ports: load, clear, data/addr in/out.

Test Plan:
- Reset release, zero-wait memory returning addr as data -> imem_addr 0,4,8,…; IFID_instr tracks them 1 cycle later; IFID_valid=1 from the 2nd post-reset edge.
- IFWrite=PCWrite=0 for 3 cycles while ack arrives for addr 0x0008 -> S_HOLD, imem_req=0, IF/ID frozen; on release IFID_pc=0x0008 and the next request is 0x000C.
- br_taken with br_target=0x0042 in S_WAIT, ack delayed 3 cycles:
  - imem_addr stays at the old value until ack and that data is dropped.
  - The next request is 0x0040; IFID_valid=0 throughout.
- br_taken while stalled with IFWrite=0 -> IF/ID becomes NOP and valid=0 anyway; the hold buffer is cleared.
- Same-cycle ack and br_taken -> acked word never reaches IF/ID; next imem_addr = br_target.
- Reset asserted in S_DROP and in S_HOLD -> all outputs immediately at reset values, no clock needed; restart fetches RESET_PC.
- PC at 0xFFFC advancing -> next address 0x0000.
